// File: rtl/mux_arb_pkg.sv
// Shared definitions for the round-robin mux arbiter.
//   ARB_N          number of requesters (fixed at 8, one per mux input)
//   ARB_SELW       mux select width
//   arb_state_t    arbiter state encoding
//   onehot_to_idx  binary index of a one-hot (or zero) vector
package mux_arb_pkg;

   localparam int unsigned ARB_N    = 8;
   localparam int unsigned ARB_SELW = 3;

   typedef enum logic [0:0] {ARB_IDLE, ARB_OWNED} arb_state_t;

   // Returns 0 for an all-zero input.
   function automatic logic [ARB_SELW-1:0] onehot_to_idx(input logic [ARB_N-1:0] oh);
      logic [ARB_SELW-1:0] idx;
      idx = '0;
      for (int i = 0; i < ARB_N; i++) begin
         if (oh[i]) idx = idx | ARB_SELW'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_pick8.sv
// Circular first-set-bit picker for eight requesters.
//   req     in   8  request vector
//   start   in   3  index where the circular search begins
//   found   out  1  any request set
//   idx     out  3  index of the first set bit at or after start
//   onehot  out  8  one-hot of idx, zero when nothing is found
module rr_pick8
   import mux_arb_pkg::*;
(
   input  logic [ARB_N-1:0]    req,
   input  logic [ARB_SELW-1:0] start,
   output logic                found,
   output logic [ARB_SELW-1:0] idx,
   output logic [ARB_N-1:0]    onehot
);

   logic [2*ARB_N-1:0]  dbl;
   logic [ARB_N-1:0]    rot;
   logic [ARB_N-1:0]    first;
   logic [ARB_SELW-1:0] off;

   always_comb begin
      // Rotate so that bit 'start' lands at position 0, then take the lowest set bit.
      dbl    = {req, req} >> start;
      rot    = dbl[ARB_N-1:0];
      first  = rot & (~rot + 8'd1);
      off    = onehot_to_idx(first);
      found  = |req;
      idx    = start + off;
      onehot = found ? (8'd1 << idx) : '0;
   end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter owning the select of a shared 8:1 mux.
//   clk    in   1  rising-edge clock
//   rst_n  in   1  asynchronous active-low reset
//   req    in   8  level-sensitive requests
//   gnt    out  8  one-hot grant, zero when idle
//   sel    out  3  mux select, index of gnt; holds its last value when idle
//   busy   out  1  a grant is active
// Optional feature macro: MUX_ARB_HOLD_LIMIT_EN forces a release after MAX_HOLD
// consecutive grant cycles of one owner.
module mux_rr_arbiter
   import mux_arb_pkg::*;
#(
   parameter int unsigned N        = 8,
   parameter int unsigned SELW     = 3,
   parameter int unsigned MAX_HOLD = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N-1:0]    req,
   output logic [N-1:0]    gnt,
   output logic [SELW-1:0] sel,
   output logic            busy
);

   if (N != ARB_N || SELW != ARB_SELW) begin : g_bad_width
      $error("mux_rr_arbiter supports only N=8, SELW=3");
   end
   if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_hold
      $error("mux_rr_arbiter MAX_HOLD must be 1..255");
   end

   arb_state_t      state_q;
   logic [SELW-1:0] ptr_q;
   logic [SELW-1:0] sel_q;
   logic [N-1:0]    gnt_q;
   logic            busy_q;

   logic [SELW-1:0] pick_start;
   logic            pick_found;
   logic [SELW-1:0] pick_idx;
   logic [N-1:0]    pick_onehot;
   logic            hold_hit;
   logic            release_now;

`ifdef MUX_ARB_HOLD_LIMIT_EN
   logic [7:0] hold_q;
   // hold_q counts cycles already spent by the owner, so the grant lasts MAX_HOLD cycles.
   assign hold_hit = (hold_q == 8'(MAX_HOLD - 1));
`else
   assign hold_hit = 1'b0;
`endif

   // While owned, the next search always starts just after the current owner.
   assign pick_start  = (state_q == ARB_OWNED) ? sel_q + 3'd1 : ptr_q;
   assign release_now = !req[sel_q] || hold_hit;

   rr_pick8 u_pick (
      .req    (req),
      .start  (pick_start),
      .found  (pick_found),
      .idx    (pick_idx),
      .onehot (pick_onehot)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ARB_IDLE;
         ptr_q   <= '0;
         sel_q   <= '0;
         gnt_q   <= '0;
         busy_q  <= 1'b0;
`ifdef MUX_ARB_HOLD_LIMIT_EN
         hold_q  <= '0;
`endif
      end else begin
         case (state_q)
            ARB_IDLE: begin
               if (pick_found) begin
                  state_q <= ARB_OWNED;
                  gnt_q   <= pick_onehot;
                  sel_q   <= pick_idx;
                  busy_q  <= 1'b1;
`ifdef MUX_ARB_HOLD_LIMIT_EN
                  hold_q  <= '0;
`endif
               end
            end
            ARB_OWNED: begin
               if (release_now) begin
                  ptr_q <= pick_start;
                  // On a forced release the owner is searched last, so it only wins if alone.
                  if (pick_found) begin
                     gnt_q  <= pick_onehot;
                     sel_q  <= pick_idx;
`ifdef MUX_ARB_HOLD_LIMIT_EN
                     hold_q <= '0;
`endif
                  end else begin
                     state_q <= ARB_IDLE;
                     gnt_q   <= '0;
                     busy_q  <= 1'b0;
                  end
               end else begin
`ifdef MUX_ARB_HOLD_LIMIT_EN
                  hold_q <= hold_q + 8'd1;
`endif
               end
            end
            default: state_q <= ARB_IDLE;
         endcase
      end
   end

   assign gnt  = gnt_q;
   assign sel  = sel_q;
   assign busy = busy_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
module tb_mux_rr_arbiter;

   logic       clk;
   logic       rst_n;
   logic [7:0] req;
   logic [7:0] gnt;
   logic [2:0] sel;
   logic       busy;

   int n_cmp;
   int n_err;

   mux_rr_arbiter #(
      .N        (8),
      .SELW     (3),
      .MAX_HOLD (16)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req),
      .gnt   (gnt),
      .sel   (sel),
      .busy  (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] req;
      logic [7:0] gnt;
      logic [2:0] sel;
      logic       busy;
   } vec_t;

   vec_t vecs[15];

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string name, input logic [7:0] eg, input logic [2:0] es,
                            input logic eb);
      chk({name, ".gnt"}, gnt, eg);
      chk({name, ".sel"}, {5'd0, sel}, {5'd0, es});
      chk({name, ".busy"}, {7'd0, busy}, {7'd0, eb});
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req   = 8'h00;
      step();
      step();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;

      // Directed sequence from reset: ptr=0, idle.
      vecs[0]  = '{8'h24, 8'h04, 3'd2, 1'b1};
      vecs[1]  = '{8'h20, 8'h20, 3'd5, 1'b1};  // switch 2->5, no bubble
      vecs[2]  = '{8'h21, 8'h20, 3'd5, 1'b1};  // others ignored while held
      vecs[3]  = '{8'h01, 8'h01, 3'd0, 1'b1};  // search from 6 wraps to 0
      vecs[4]  = '{8'h00, 8'h00, 3'd0, 1'b0};  // idle, ptr=1
      vecs[5]  = '{8'h08, 8'h08, 3'd3, 1'b1};
      vecs[6]  = '{8'h00, 8'h00, 3'd3, 1'b0};  // sel held, ptr=4
      vecs[7]  = '{8'h11, 8'h10, 3'd4, 1'b1};  // from ptr 4, 4 beats 0
      vecs[8]  = '{8'h01, 8'h01, 3'd0, 1'b1};
      vecs[9]  = '{8'h81, 8'h01, 3'd0, 1'b1};
      vecs[10] = '{8'h80, 8'h80, 3'd7, 1'b1};
      vecs[11] = '{8'h02, 8'h02, 3'd1, 1'b1};  // 7 releases, ptr wraps to 0
      vecs[12] = '{8'h00, 8'h00, 3'd1, 1'b0};  // ptr=2
      vecs[13] = '{8'h03, 8'h01, 3'd0, 1'b1};  // from 2 wraps round to 0
      vecs[14] = '{8'h00, 8'h00, 3'd0, 1'b0};

      // Reset with every request asserted.
      rst_n = 1'b0;
      req   = 8'hFF;
      #1;
      check_out("rst_async", 8'h00, 3'd0, 1'b0);
      step();
      step();
      check_out("rst_held", 8'h00, 3'd0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      check_out("rst_first", 8'h01, 3'd0, 1'b1);

      // Table-driven directed vectors.
      do_reset();
      foreach (vecs[i]) begin
         req = vecs[i].req;
         step();
         check_out($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].sel, vecs[i].busy);
      end

      // All requesting, each owner drops for one cycle: order 0..7 then 0.
      do_reset();
      req = 8'hFF;
      step();
      check_out("rr0", 8'h01, 3'd0, 1'b1);
      for (int i = 1; i <= 8; i++) begin
         req = 8'hFF & ~(8'd1 << ((i - 1) % 8));
         step();
         check_out($sformatf("rr%0d", i), 8'd1 << (i % 8), 3'(i % 8), 1'b1);
      end

      // Owner 6 held while requester 1 waits.
      do_reset();
      req = 8'h40;
      step();
      check_out("hold_grant", 8'h40, 3'd6, 1'b1);
      req = 8'h42;
`ifdef MUX_ARB_HOLD_LIMIT_EN
      for (int j = 1; j <= 20; j++) begin
         step();
         if (j < 16) chk($sformatf("hold%0d", j), gnt, 8'h40);
         else        chk($sformatf("hold%0d", j), gnt, 8'h02);
      end
`else
      for (int j = 1; j <= 50; j++) begin
         step();
         chk($sformatf("hold%0d", j), gnt, 8'h40);
      end
`endif
      req = 8'h00;
      step();
      chk("hold_rel.busy", {7'd0, busy}, 8'h00);

      // Single-cycle pulse on requester 3.
      req = 8'h08;
      step();
      check_out("pulse", 8'h08, 3'd3, 1'b1);
      req = 8'h00;
      step();
      check_out("pulse_idle", 8'h00, 3'd3, 1'b0);
      step();
      check_out("pulse_idle2", 8'h00, 3'd3, 1'b0);

      // Asynchronous reset between edges while a grant is active.
      req = 8'h10;
      step();
      check_out("pre_rst", 8'h10, 3'd4, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check_out("mid_rst", 8'h00, 3'd0, 1'b0);
      req = 8'h81;
      @(negedge clk);
      rst_n = 1'b1;
      step();
      check_out("post_rst", 8'h01, 3'd0, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

Round-robin arbiter that shares one 8:1 bit-select mux between eight requesters. It grants one requester at a time and drives the mux `sel` lines with the registered index of the owner. A grant is held while the owner keeps requesting. The next owner is chosen fairly, with the search starting after the previous owner. It sits directly in front of the 8:1 mux tree (3-bit select, `sel[0]` on the first layer) and is the only driver of its select.

## Interface
- `N`, 8, number of requesters; fixed at 8 to match the mux width.
- `SELW`, 3, select width, $clog2(N).
- `MAX_HOLD`, 16, maximum consecutive grant cycles per owner; used only with `MUX_ARB_HOLD_LIMIT_EN`. Legal range 1..255.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  8  request per requester; level-sensitive.
- `gnt`  out  8  one-hot grant; all-zero when idle.
- `sel`  out  3  mux select, equal to the binary index of `gnt`; holds its last value when idle.
- `busy`  out  1  high whenever any grant is active.

## Operation
- Two states, IDLE and OWNED.
- **IDLE**
  - If `req` is non-zero, pick the first set bit at or after `ptr`, searching circularly.
  - Register its one-hot in `gnt` and its index in `sel`, set `busy`, and go to OWNED.
  - If `req` is zero, stay in IDLE.
- **OWNED, owner k**
  - If `req[k]` is still high, hold `gnt`, `sel` and `busy` unchanged.
  - If `req[k]` is low, release. Set `ptr` = k+1 mod 8 (7 wraps to 0).
  - At release, if any other request is set, search from k+1, switch directly to the new owner at the same edge with no idle bubble, and stay in OWNED.
  - At release, if no other request is set, go to IDLE: `gnt`=0, `busy`=0, `sel` keeps k.
- `ptr` is 3 bits and is updated only on release or forced release. A held grant never moves it.
- Only the owner's request line affects a held grant. Requests from other requesters are ignored until release.
- Invariant: `gnt` is zero or one-hot, and `sel` == index(`gnt`) whenever `busy`=1.

## Timing
- Reset, asynchronous, takes effect immediately:
  - outputs: `gnt`=0, `sel`=0, `busy`=0;
  - internal: `ptr`=0, state IDLE, hold counter 0.
- Reset asserted mid-grant drops the grant at once. After reset the search restarts at requester 0.
- Grant latency: `req` rising before edge T gives `gnt`/`sel` valid after edge T. That is one cycle, with registered outputs only.
- Release latency: `req[k]` falling before edge T removes `gnt[k]` after edge T.
- A requester must keep `req` asserted until it sees its `gnt`. Dropping `req` before that is legal; no grant is issued to it.
- Simultaneous requests are resolved in round-robin order from `ptr`. All eight asserted continuously with one-cycle holds gives the order 0,1,…,7,0 with no gaps.
- `sel` changes only at clock edges. The downstream mux output is valid in the same cycle `gnt` is seen.

## Configuration
- `MUX_ARB_HOLD_LIMIT_EN` defined:
  - An 8-bit hold counter counts grant cycles of the current owner.
  - When it reaches `MAX_HOLD`, force a release at that edge even if `req[k]` is still high. Rotate as in a normal release.
  - k may be re-granted only if no other requester is waiting.
  - The counter clears on every new grant and on reset.
- `MUX_ARB_HOLD_LIMIT_EN` undefined: no counter, a grant is held indefinitely, and `MAX_HOLD` is ignored.

## Structure
- Shared package `mux_arb_pkg`: constants `ARB_N`=8 and `ARB_SELW`=3, state enum `arb_state_t` {ARB_IDLE, ARB_OWNED}, and function `onehot_to_idx`.
- One combinational sub-module, `rr_pick8`.
  - Inputs: `req[7:0]` and `start[2:0]`.
  - Outputs: `found`, `idx[2:0]`, `onehot[7:0]`.
  - Implementation: a rotate-then-priority-encode picker, instantiated once.
- The top level holds the state register, `ptr`, output registers and the optional hold counter.

## Test plan
- Reset with `req`=8'hFF held → `gnt`=0, `sel`=0, `busy`=0 during reset. The first edge after release gives `gnt`=8'h01, `sel`=0.
- `req`=8'h24, owner 2 then drops `req[2]` → `gnt` changes 8'h04 → 8'h20 at that edge with no idle cycle, and `sel` 2 → 5.
- All requests held, each owner drops its `req` for one cycle after being granted → grant order 0..7, then 0 again (wrap 7 → 0).
- Owner 6 holds while `req[1]` is asserted for 50 cycles → `gnt` stays 8'h40 throughout. With `MUX_ARB_HOLD_LIMIT_EN` and `MAX_HOLD`=16, `gnt` instead moves to 8'h02 after 16 grant cycles.
- `req[3]` pulsed alone for one cycle → `gnt`=8'h08 for one cycle, then IDLE with `busy`=0 and `sel` held at 3.
- Async reset asserted mid-grant between edges → `gnt`/`busy` clear immediately. After reset, `req`=8'h81 grants 0 first.
